// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Bit order of every segment vector: bit6..bit0 = g,f,e,d,c,b,a.
// All segment codes are active-low (common-anode display): 0 lights a segment.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Decode one nibble. Codes 10..15 are letters in hex mode, dark in BCD mode.
  function automatic logic [6:0] seg7_encode(input logic [3:0] code, input logic hex_mode);
    logic [6:0] v_seg;
    v_seg = SEG_OFF;
    case (code)
      4'd0:  v_seg = SEG_0;
      4'd1:  v_seg = SEG_1;
      4'd2:  v_seg = SEG_2;
      4'd3:  v_seg = SEG_3;
      4'd4:  v_seg = SEG_4;
      4'd5:  v_seg = SEG_5;
      4'd6:  v_seg = SEG_6;
      4'd7:  v_seg = SEG_7;
      4'd8:  v_seg = SEG_8;
      4'd9:  v_seg = SEG_9;
      4'd10: v_seg = hex_mode ? SEG_A : SEG_OFF;
      4'd11: v_seg = hex_mode ? SEG_B : SEG_OFF;
      4'd12: v_seg = hex_mode ? SEG_C : SEG_OFF;
      4'd13: v_seg = hex_mode ? SEG_D : SEG_OFF;
      4'd14: v_seg = hex_mode ? SEG_E : SEG_OFF;
      default: v_seg = hex_mode ? SEG_F : SEG_OFF;
    endcase
    return v_seg;
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero suppression mask: bit i set means digit i must be dark because
// it and every more-significant digit hold zero. Digit 0 is never masked.
module seg7_lz_mask
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic                    i_enable,
  output logic [NUM_DIGITS-1:0]   o_mask
);

  logic w_zero_run;

  // Walk from the most-significant digit down, tracking an unbroken run of zeros.
  always_comb begin
    o_mask     = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (i_digits[4*i +: 4] == 4'd0);
      o_mask[i]  = i_enable & w_zero_run;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver.
// Each digit slot lasts REFRESH_DIV cycles: one dark BLANK cycle (anti-ghosting)
// followed by REFRESH_DIV-1 DRIVE cycles. All display outputs are registered and
// are computed from the next FSM state/index and the current shadow registers.
// Strobe semantics: load has no handshake; whenever load is 1 at a clk edge the
// shadow registers capture digits_in/dp_in/blank_in, with no back-pressure.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode_active,
  output logic [6:0]              segments,
  output logic                    dp_out,
  output logic [0:0]              o_dbg_state
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic HEX = (HEX_MODE != 0);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [0:0]              r_state;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_segments;
  logic                    r_dp_out;

  logic                    w_tick;
  logic [0:0]              w_state_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [3:0]              w_nibble;
  logic                    w_dark;
  logic [NUM_DIGITS-1:0]   w_anode_nxt;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;

  assign w_tick       = (r_presc == PRE_MAX);
  assign anode_active = r_anode;
  assign segments     = r_segments;
  assign dp_out       = r_dp_out;
  assign o_dbg_state  = r_state;

  seg7_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .i_digits (r_digits),
    .i_enable (lz_suppress),
    .o_mask   (w_lz_mask)
  );

  // Shadow registers: the display only ever reads these, so inputs may change freely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_dp     <= '0;
      r_blank  <= '0;
    end else if (load) begin
      r_digits <= digits_in;
      r_dp     <= dp_in;
      r_blank  <= blank_in;
    end
  end

  // Refresh prescaler, free-running modulo REFRESH_DIV.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // Next-state logic: BLANK lasts one cycle, DRIVE ends on tick and advances the digit.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_BLANK: w_state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        if (w_tick) begin
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
        end
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

  // FSM state and digit index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_BLANK;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Output decode for the cycle about to start; blanked/suppressed digits keep their anode.
  always_comb begin
    w_nibble    = r_digits[{w_idx_nxt, 2'b00} +: 4];
    w_dark      = r_blank[w_idx_nxt] | w_lz_mask[w_idx_nxt];
    w_anode_nxt = '1;
    w_seg_nxt   = SEG_OFF;
    w_dp_nxt    = 1'b1;
    if (w_state_nxt == ST_DRIVE) begin
      w_anode_nxt[w_idx_nxt] = 1'b0;
      if (!w_dark) begin
        w_seg_nxt = seg7_encode(w_nibble, HEX);
        w_dp_nxt  = ~r_dp[w_idx_nxt];
      end
    end
  end

  // Registered display pins; reset forces everything dark immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_anode    <= '1;
      r_segments <= SEG_OFF;
      r_dp_out   <= 1'b1;
    end else begin
      r_anode    <= w_anode_nxt;
      r_segments <= w_seg_nxt;
      r_dp_out   <= w_dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// Two instances (BCD and hex) share the stimulus. Each expected cycle is one
// entry {anode[3:0], seg_bcd[6:0], seg_hex[6:0], dp}; a frame is 16 cycles,
// slot 4*d is the dark gap before digit d and slots 4*d+1..4*d+3 drive digit d.
module tb_seg7_scan_driver;

  localparam int W = 19;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SB   = 7'b0000011;
  localparam logic [6:0] SE   = 7'b0000110;
  localparam logic [6:0] SOFF = 7'b1111111;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_suppress;
  logic        load;
  logic [3:0]  anode_active;
  logic [6:0]  segments;
  logic        dp_out;
  logic [0:0]  dbg_state;
  logic [3:0]  anode_hex;
  logic [6:0]  seg_hex;
  logic        dp_hex;
  logic [0:0]  dbg_state_hex;

  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_miss;

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_suppress(lz_suppress), .load(load),
    .anode_active(anode_active), .segments(segments), .dp_out(dp_out),
    .o_dbg_state(dbg_state)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_suppress(lz_suppress), .load(load),
    .anode_active(anode_hex), .segments(seg_hex), .dp_out(dp_hex),
    .o_dbg_state(dbg_state_hex)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, %0d entries pending, required 0", exp_q.size());
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] an_of(input int d);
    case (d)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [W-1:0] e);
    exp_q.push_back(e);
  endtask

  // Push expected entries for frame slots first..last. sb/sh = {d3,d2,d1,d0}.
  task automatic frame_push(input logic [27:0] sb, input logic [27:0] sh,
                            input logic [3:0] dpn, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      int d;
      d = k / 4;
      if (k % 4 == 0) push_one({4'b1111, SOFF, SOFF, 1'b1});
      else            push_one({an_of(d), sb[d*7 +: 7], sh[d*7 +: 7], dpn[d]});
    end
  endtask

  // Monitor: one output per cycle, sampled mid-cycle, compared against the queue head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      e = exp_q.pop_front();
      a = {anode_active, segments, seg_hex, dp_out};
      n_vec++;
      if (a !== e || anode_hex !== e[18:15] || dp_hex !== e[0]) begin
        n_miss++;
        $display("FAIL vec%0d: anode=%b seg=%b seg_hex=%b dp=%b (hex anode=%b dp=%b), required anode=%b seg=%b seg_hex=%b dp=%b",
                 n_vec, anode_active, segments, seg_hex, dp_out, anode_hex, dp_hex,
                 e[18:15], e[14:8], e[7:1], e[0]);
      end
    end
  end

  // Stimulus: each frame is pushed at the start of its dark slot 0.
  initial begin
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    digits_in = '0;
    dp_in = '0;
    blank_in = '0;
    lz_suppress = 1'b0;
    load = 1'b0;
    repeat (3) step();

    // Reset state, then first frame with cleared shadow: every digit shows 0.
    frame_push({S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b1111, 0, 15);
    rst_n = 1'b1;
    repeat (15) step();
    digits_in = 16'h1234; dp_in = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;

    // 1234 with dp on digit 2; digits_in changes without load mid-frame.
    frame_push({S1, S2, S3, S4}, {S1, S2, S3, S4}, 4'b1011, 0, 15);
    repeat (5) step();
    digits_in = 16'h9999;
    repeat (10) step();
    digits_in = 16'h0050; dp_in = 4'b0000; lz_suppress = 1'b1; load = 1'b1;
    step();
    load = 1'b0;

    // Leading-zero suppression of 0050.
    frame_push({SOFF, SOFF, S5, S0}, {SOFF, SOFF, S5, S0}, 4'b1111, 0, 15);
    repeat (15) step();
    digits_in = 16'h0000; load = 1'b1;
    step();
    load = 1'b0;

    // Value zero with suppression: only digit 0 lit.
    frame_push({SOFF, SOFF, SOFF, S0}, {SOFF, SOFF, SOFF, S0}, 4'b1111, 0, 15);
    repeat (15) step();
    digits_in = 16'h7AEB; dp_in = 4'b0001; lz_suppress = 1'b0; load = 1'b1;
    step();
    load = 1'b0;

    // BCD vs hex letters; dp still shown on digit 0 whose BCD code is dark.
    frame_push({S7, SOFF, SOFF, SOFF}, {S7, SA, SE, SB}, 4'b1110, 0, 15);
    repeat (15) step();
    blank_in = 4'b0001; load = 1'b1;
    step();
    load = 1'b0;

    // blank_in[0]: digit 0 dark and its dp suppressed.
    frame_push({S7, SOFF, SOFF, SOFF}, {S7, SA, SE, SOFF}, 4'b1111, 0, 15);
    repeat (16) step();

    // Load on the dark-to-drive edge: first drive cycle still shows the old shadow.
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000; load = 1'b1;
    push_one({4'b1111, SOFF, SOFF, 1'b1});
    push_one({4'b1110, SOFF, SOFF, 1'b1});
    frame_push({S1, S2, S3, S4}, {S1, S2, S3, S4}, 4'b1111, 2, 15);
    step();
    load = 1'b0;
    repeat (15) step();

    // Reset during the first drive cycle of digit 2, then a fresh frame of zeros.
    frame_push({S1, S2, S3, S4}, {S1, S2, S3, S4}, 4'b1111, 0, 9);
    frame_push({S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b1111, 0, 15);
    repeat (9) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (15) step();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
